// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequential ALU. Operands are accepted on an
//            in_valid/in_ready handshake and the result is registered.
//            MUL is an iterative shift-add over WIDTH cycles; every other
//            opcode completes in one cycle. The result is held until the
//            consumer takes it (out_valid/out_ready).
// Ports    : clk        in   1      rising-edge clock
//            rst        in   1      asynchronous reset, active-high
//            in_valid   in   1      operands/opcode valid
//            in_ready   out  1      block can accept operands
//            oc         in   3      opcode (ADD,SUB,MUL,AND,OR,XOR,NOT,LTU)
//            a, b       in   WIDTH  operands
//            out_valid  out  1      f holds a result
//            out_ready  in   1      consumer takes result
//            f          out  WIDTH  registered result
//            busy       out  1      multiply in progress
//            flags      out  4      {Z,C,V,N}; only when ALU_FLAGS_EN is defined
// Config   : `define ALU_FLAGS_EN to add the flags port and flag logic.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       oc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_MUL  = 2'd1;
  localparam logic [1:0] c_S_HOLD = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_MUL = 3'b010;
  localparam logic [2:0] c_OP_AND = 3'b011;
  localparam logic [2:0] c_OP_OR  = 3'b100;
  localparam logic [2:0] c_OP_XOR = 3'b101;
  localparam logic [2:0] c_OP_NOT = 3'b110;
  localparam logic [2:0] c_OP_LTU = 3'b111;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_accept;
  logic               w_mul_last;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [2*WIDTH-1:0] w_prod;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE: if (in_valid) state_d = (oc == c_OP_MUL) ? c_S_MUL : c_S_HOLD;
      c_S_MUL:  if (w_mul_last) state_d = c_S_HOLD;
      c_S_HOLD: if (out_ready) state_d = c_S_IDLE;
      default:  state_d = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      c_S_IDLE: in_ready  = ~rst;
      c_S_MUL:  busy      = 1'b1;
      c_S_HOLD: out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign w_accept   = in_ready & in_valid;
  // The counter starts at 0 on acceptance, so the last partial product is
  // taken when it reads WIDTH-1; it stops at WIDTH and never wraps.
  assign w_mul_last = busy && (cnt_q == CNT_W'(WIDTH - 1));

  // --------------------------------------------------------------------------
  // Single-cycle ALU, evaluated on the live operands at acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    w_add = {1'b0, a} + {1'b0, b};
    w_sub = {1'b0, a} - {1'b0, b};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (oc)
      c_OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];  // borrow, i.e. a < b
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_XOR: w_res = a ^ b;
      c_OP_NOT: w_res = ~a;
      c_OP_LTU: w_res[0] = (a < b);
      default:  ;  // MUL is handled by the iterative datapath
    endcase
  end

  // Shift-add step: multiplicand shifts left, multiplier shifts right and
  // its LSB selects whether the shifted multiplicand is accumulated.
  assign w_prod = acc_q + (mplr_q[0] ? mcand_q : '0);

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    f_d     = f_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    if (w_accept) begin
      if (oc == c_OP_MUL) begin
        acc_d   = '0;
        mcand_d = {{WIDTH{1'b0}}, a};
        mplr_d  = b;
        cnt_d   = '0;
      end else begin
        f_d = w_res;
      end
    end else if (busy) begin
      acc_d   = w_prod;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (w_mul_last) f_d = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q     <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      f_q     <= f_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f = f_q;

`ifdef ALU_FLAGS_EN
  // Flags are written on exactly the same edges as f so the pair is coherent.
  logic [3:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (w_accept && (oc != c_OP_MUL)) begin
      flags_d = {(w_res == '0), w_c, w_v, w_res[WIDTH-1]};
    end else if (w_mul_last) begin
      flags_d = {(w_prod[WIDTH-1:0] == '0), (|w_prod[2*WIDTH-1:WIDTH]),
                 1'b0, w_prod[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  // Carry/overflow only feed the flags; keep them visibly consumed.
  logic w_unused_flags;
  assign w_unused_flags = ^{w_c, w_v};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=4): directed scenarios,
//            an exhaustive {oc,a,b} sweep and randomized stalls, compared
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   oc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         busy;
`ifdef ALU_FLAGS_EN
  logic [3:0]   flags;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .oc        (oc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .busy      (busy)
`ifdef ALU_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic void model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                                output logic [3:0] ef, output logic [3:0] efl);
    int  r, sx, sy, s;
    bit  c, v;
    sx = (x >= 8) ? int'(x) - 16 : int'(x);
    sy = (y >= 8) ? int'(y) - 16 : int'(y);
    c = 0; v = 0; r = 0; s = 0;
    case (op)
      3'd0: begin r = int'(x) + int'(y); c = (r > 15); s = sx + sy; v = (s > 7) || (s < -8); end
      3'd1: begin r = int'(x) - int'(y); c = (x < y);  s = sx - sy; v = (s > 7) || (s < -8); end
      3'd2: begin r = int'(x) * int'(y); c = (r > 15); end
      3'd3: r = int'(x & y);
      3'd4: r = int'(x | y);
      3'd5: r = int'(x ^ y);
      3'd6: r = 15 - int'(x);
      default: r = (x < y) ? 1 : 0;
    endcase
    ef  = 4'(r);
    efl = {(ef == 4'd0), c, v, ef[3]};
  endfunction

  // Issue one op from IDLE (called #1 after an edge) and wait for out_valid.
  // Returns in the first cycle where out_valid is seen.
  task automatic do_op(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                       input string tag);
    logic [3:0] ef, efl;
    int lat;
    model(op, x, y, ef, efl);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; oc = op; a = x; b = y;
    @(posedge clk); #1;
    // scramble operands: must have no effect after acceptance
    in_valid = 1'b0; oc = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 16) begin
      check({tag, "_busy_run"}, busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, (op == 3'b010) ? 5 : 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_in_ready_hold"}, in_ready, 0);
    check({tag, "_f"}, f, ef);
`ifdef ALU_FLAGS_EN
    check({tag, "_flags"}, flags, efl);
`else
    if (efl == 4'hF) check({tag, "_flags_model"}, efl[0], 1'b1);  // efl unused otherwise
`endif
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0] ef, efl;
    int stall;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; oc = '0; a = '0; b = '0;
    #1 rst = 1'b1;
    #1;
    // --- reset state
    check("rst_f", f, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
`ifdef ALU_FLAGS_EN
    check("rst_flags", flags, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // --- ADD 7+1: signed overflow, negative
    out_ready = 1'b1;
    do_op(3'd0, 4'b0111, 4'b0001, "add");
    check("add_f_lit", f, 4'b1000);
`ifdef ALU_FLAGS_EN
    check("add_flags_lit", flags, 4'b0011);
`endif
    consume("add");

    // --- SUB 3-5 with backpressure; offered ops during HOLD are ignored
    out_ready = 1'b0;
    do_op(3'd1, 4'b0011, 4'b0101, "sub");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; oc = 3'd0; a = 4'b1111; b = 4'b1111;
      @(posedge clk); #1;
      check("bp_f", f, 4'b1110);
`ifdef ALU_FLAGS_EN
      check("bp_flags", flags, 4'b0101);
`endif
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    consume("sub");
    check("bp_f_after", f, 4'b1110);

    // --- LTU 0<1
    do_op(3'd7, 4'b0000, 4'b0001, "ltu");
    check("ltu_f_lit", f, 4'b0001);
    consume("ltu");

    // --- MUL 5*3 and 7*7
    do_op(3'd2, 4'd5, 4'd3, "mul53");
    check("mul53_f_lit", f, 4'b1111);
`ifdef ALU_FLAGS_EN
    check("mul53_c", flags[2], 0);
`endif
    consume("mul53");
    do_op(3'd2, 4'd7, 4'd7, "mul77");
    check("mul77_f_lit", f, 4'b0001);
`ifdef ALU_FLAGS_EN
    check("mul77_c", flags[2], 1);
`endif
    consume("mul77");

    // --- reset in MUL cycle 2 aborts the multiply
    in_valid = 1'b1; oc = 3'd2; a = 4'd5; b = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_f", f, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    do_op(3'd0, 4'b0010, 4'b0010, "add_after_rst");
    check("add_after_rst_lit", f, 4'b0100);
    consume("add_after_rst");

    // --- exhaustive sweep with out_ready held high
    for (int op = 0; op < 8; op++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          do_op(3'(op), 4'(x), 4'(y), "sweep");
          consume("sweep");
        end

    // --- random ops with random consumer stalls and ignored offers
    for (int i = 0; i < 100; i++) begin
      logic [2:0] rop;
      logic [3:0] rx, ry;
      rop = 3'($urandom); rx = 4'($urandom); ry = 4'($urandom);
      model(rop, rx, ry, ef, efl);
      out_ready = 1'b0;
      do_op(rop, rx, ry, "rand");
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom); oc = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
        @(posedge clk); #1;
        check("rand_stall_f", f, ef);
        check("rand_stall_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      consume("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
